// File: rtl/contador_inicializacion_param.sv
// Parameterised step counter with IDLE/RUN/DONE sequencing, dwell prescaler and pause.
// Build macro CONTADOR_INIT_DONE_PULSE_EN turns done into a one-cycle pulse; otherwise done is a level.
module contador_inicializacion_param #(
  parameter int WIDTH    = 3,
  parameter int TERMINAL = 7,
  parameter int DWELL    = 1,
  parameter int WRAP     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             pausa,
  output logic [WIDTH-1:0] salida,
  output logic             busy,
  output logic             paso,
  output logic             done,
  output logic [1:0]       estado
);

  localparam int PW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(DWELL - 1);
  localparam logic [WIDTH-1:0] TERM     = WIDTH'(TERMINAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] salida_nx;
  logic [WIDTH-1:0] salida_inc;
  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_nx;
  logic             adv;
  logic             adv_nx;
  logic             paso_nx;
  logic             done_pulse_nx;

  assign salida_inc = salida + WIDTH'(1);

  // A completed dwell raises adv; the step itself is applied on the following
  // unpaused RUN edge, so pausa freezes both the prescaler and a pending step.
  always_comb begin
    state_nx      = state;
    salida_nx     = salida;
    pre_nx        = pre;
    adv_nx        = adv;
    paso_nx       = 1'b0;
    done_pulse_nx = 1'b0;
    if (!En) begin
      state_nx  = IDLE;
      salida_nx = '0;
      pre_nx    = '0;
      adv_nx    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nx  = RUN;
          salida_nx = '0;
          pre_nx    = '0;
          adv_nx    = 1'b0;
        end
        RUN: begin
          if (!pausa) begin
            if (pre == PRE_LAST) begin
              pre_nx = '0;
              adv_nx = 1'b1;
            end else begin
              pre_nx = pre + PW'(1);
              adv_nx = 1'b0;
            end
            if (adv) begin
              paso_nx = 1'b1;
              if (WRAP != 0) begin
                salida_nx = (salida == TERM) ? '0 : salida_inc;
              end else begin
                salida_nx = salida_inc;
                if (salida_inc == TERM) begin
                  state_nx      = DONE;
                  pre_nx        = '0;
                  adv_nx        = 1'b0;
                  done_pulse_nx = 1'b1;
                end
              end
            end
          end
        end
        DONE: begin
          salida_nx = TERM;
          pre_nx    = '0;
          adv_nx    = 1'b0;
        end
        default: begin
          state_nx  = IDLE;
          salida_nx = '0;
          pre_nx    = '0;
          adv_nx    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      salida <= '0;
      pre    <= '0;
      adv    <= 1'b0;
      paso   <= 1'b0;
    end else begin
      state  <= state_nx;
      salida <= salida_nx;
      pre    <= pre_nx;
      adv    <= adv_nx;
      paso   <= paso_nx;
    end
  end

`ifdef CONTADOR_INIT_DONE_PULSE_EN
  logic done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_pulse_nx;
    end
  end

  assign done = done_q;
`else
  assign done = (state == DONE);
`endif

  assign busy   = (state == RUN);
  assign estado = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (salida <= TERM);
      assert (!(busy && (state == DONE)));
    end
  end

endmodule

// File: tb/tb_contador_inicializacion_param.sv
// Bench for contador_inicializacion_param: four parameter sets share one stimulus stream and are
// checked every cycle against a step-count model, plus literal sequences for the canonical runs.
module tb_contador_inicializacion_param;

  localparam int NI = 4;
  localparam int P_T [NI] = '{7, 3, 5, 9};
  localparam int P_D [NI] = '{1, 4, 1, 3};
  localparam int P_W [NI] = '{0, 0, 1, 1};

  logic clk;
  logic reset;
  logic en;
  logic pausa;

  logic [2:0] sal_a, sal_b, sal_c;
  logic [3:0] sal_d;
  logic [1:0] est_a, est_b, est_c, est_d;
  logic busy_a, busy_b, busy_c, busy_d;
  logic paso_a, paso_b, paso_c, paso_d;
  logic done_a, done_b, done_c, done_d;

  int o_sal  [NI];
  int o_busy [NI];
  int o_paso [NI];
  int o_done [NI];

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  contador_inicializacion_param #(.WIDTH(3), .TERMINAL(7), .DWELL(1), .WRAP(0)) dut_a (
    .clk(clk), .reset(reset), .En(en), .pausa(pausa),
    .salida(sal_a), .busy(busy_a), .paso(paso_a), .done(done_a), .estado(est_a));
  contador_inicializacion_param #(.WIDTH(3), .TERMINAL(3), .DWELL(4), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .En(en), .pausa(pausa),
    .salida(sal_b), .busy(busy_b), .paso(paso_b), .done(done_b), .estado(est_b));
  contador_inicializacion_param #(.WIDTH(3), .TERMINAL(5), .DWELL(1), .WRAP(1)) dut_c (
    .clk(clk), .reset(reset), .En(en), .pausa(pausa),
    .salida(sal_c), .busy(busy_c), .paso(paso_c), .done(done_c), .estado(est_c));
  contador_inicializacion_param #(.WIDTH(4), .TERMINAL(9), .DWELL(3), .WRAP(1)) dut_d (
    .clk(clk), .reset(reset), .En(en), .pausa(pausa),
    .salida(sal_d), .busy(busy_d), .paso(paso_d), .done(done_d), .estado(est_d));

  always_comb begin
    o_sal[0] = int'(sal_a);  o_busy[0] = int'(busy_a); o_paso[0] = int'(paso_a); o_done[0] = int'(done_a);
    o_sal[1] = int'(sal_b);  o_busy[1] = int'(busy_b); o_paso[1] = int'(paso_b); o_done[1] = int'(done_b);
    o_sal[2] = int'(sal_c);  o_busy[2] = int'(busy_c); o_paso[2] = int'(paso_c); o_done[2] = int'(done_c);
    o_sal[3] = int'(sal_d);  o_busy[3] = int'(busy_d); o_paso[3] = int'(paso_d); o_done[3] = int'(done_d);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Steps completed after n unpaused RUN edges: first edge primes, then one step per dwell.
  function automatic int steps_of(input int n, input int d);
    return (n == 0) ? 0 : (n - 1) / d;
  endfunction

  // ---------------- behavioural model ----------------
  // m_st: 0 idle, 1 running, 2 finished; m_n counts unpaused running edges.
  int m_st   [NI];
  int m_n    [NI];
  int m_paso [NI];
  int m_dp   [NI];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        m_st[i] <= 0; m_n[i] <= 0; m_paso[i] <= 0; m_dp[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (!en) begin
          m_st[i] <= 0; m_n[i] <= 0; m_paso[i] <= 0; m_dp[i] <= 0;
        end else if (m_st[i] == 0) begin
          m_st[i] <= 1; m_n[i] <= 0; m_paso[i] <= 0; m_dp[i] <= 0;
        end else if (m_st[i] == 1) begin
          m_dp[i] <= 0;
          if (pausa) begin
            m_paso[i] <= 0;
          end else begin
            m_n[i]    <= m_n[i] + 1;
            m_paso[i] <= int'(steps_of(m_n[i] + 1, P_D[i]) != steps_of(m_n[i], P_D[i]));
            if (P_W[i] == 0 && steps_of(m_n[i] + 1, P_D[i]) == P_T[i]) begin
              m_st[i] <= 2;
              m_dp[i] <= 1;
            end
          end
        end else begin
          m_paso[i] <= 0; m_dp[i] <= 0;
        end
      end
    end
  end

  function automatic int exp_sal(input int i);
    int s;
    if (m_st[i] == 0) return 0;
    s = steps_of(m_n[i], P_D[i]);
    return (P_W[i] != 0) ? s % (P_T[i] + 1) : s;
  endfunction

  function automatic int exp_done(input int i);
`ifdef CONTADOR_INIT_DONE_PULSE_EN
    return m_dp[i];
`else
    return int'(m_st[i] == 2);
`endif
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("salida[%0d]", i), o_sal[i], exp_sal(i));
      check($sformatf("busy[%0d]", i), o_busy[i], int'(m_st[i] == 1));
      check($sformatf("paso[%0d]", i), o_paso[i], m_paso[i]);
      check($sformatf("done[%0d]", i), o_done[i], exp_done(i));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Literal expectations: en was raised so that the coming edge (edge 0) samples it in IDLE.
  task automatic pin_run(input string tag);
    int lvl;
    for (int k = 0; k <= 14; k++) begin
      next_edge();
      if (k >= 2 && k <= 8) check({tag, " a salida seq"}, int'(sal_a), k - 1);
      if (k == 1) check({tag, " a salida primed"}, int'(sal_a), 0);
      if (k >= 9) check({tag, " a salida hold"}, int'(sal_a), 7);
      if (k >= 2 && k <= 8) check({tag, " a paso"}, int'(paso_a), 1);
`ifdef CONTADOR_INIT_DONE_PULSE_EN
      lvl = int'(k == 8);
`else
      lvl = int'(k >= 8);
`endif
      check({tag, " a done"}, int'(done_a), lvl);
      check({tag, " a busy"}, int'(busy_a), int'(k < 8));
      if (k == 12) check({tag, " b busy before"}, int'(busy_b), 1);
      if (k == 12) check({tag, " b salida before"}, int'(sal_b), 2);
      if (k == 13) check({tag, " b busy after"}, int'(busy_b), 0);
      if (k == 13) check({tag, " b salida final"}, int'(sal_b), 3);
      check({tag, " c salida wrap"}, int'(sal_c), (k == 0) ? 0 : (k - 1) % 6);
      check({tag, " c busy"}, int'(busy_c), 1);
      check({tag, " c done"}, int'(done_c), 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    en       = 1'b0;
    pausa    = 1'b0;
    repeat (3) next_edge();
    check("reset a salida", int'(sal_a), 0);
    check("reset a busy", int'(busy_a), 0);
    reset = 1'b1;
    next_edge();
    check("idle after release", int'(busy_a), 0);

    en = 1'b1;
    pin_run("run1");

    // en low clears from DONE
    en = 1'b0;
    next_edge();
    check("clear a salida", int'(sal_a), 0);
    check("clear a done", int'(done_a), 0);

    // pause at salida=2
    en = 1'b1;
    repeat (4) next_edge();
    check("pre pause salida", int'(sal_a), 2);
    pausa = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_edge();
      check("pause hold", int'(sal_a), 2);
      check("pause paso", int'(paso_a), 0);
    end
    pausa = 1'b0;
    next_edge();
    check("resume salida", int'(sal_a), 3);
    next_edge();
    check("at four", int'(sal_a), 4);
    en = 1'b0;
    next_edge();
    check("en drop salida", int'(sal_a), 0);
    check("en drop busy", int'(busy_a), 0);

    // asynchronous reset pulse at salida=4, between edges
    en = 1'b1;
    repeat (6) next_edge();
    check("pre reset salida", int'(sal_a), 4);
    #1 reset = 1'b0;
    #1;
    check("async reset salida", int'(sal_a), 0);
    check("async reset busy", int'(busy_a), 0);
    check("async reset paso", int'(paso_a), 0);
    check("async reset done", int'(done_a), 0);
    #1 reset = 1'b1;
    pin_run("run2");

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      en    = ($urandom_range(0, 40) != 0);
      pausa = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 250) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    next_edge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
